// File: rtl/controle_multiciclo.sv
// controle_multiciclo -- multi-cycle control unit (Moore FSM).
//
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// IN waits in IOWAIT, and HLT parks the FSM in HALT until reset.
// The opcode is decoded in DECODE and latched there. From EXEC until the
// return to FETCH, every datapath select comes from that latch, so later
// changes on opcode have no effect.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   opcode [OPW-1:0]     instruction register opcode field
//   io_valid             input device has data on the bus
//   PCWrite, IRWrite     PC / instruction register load strobes
//   ALUOp [ALUW-1:0]     ALU operation
//   ALUsrc, IMsel[1:0]   ALU B operand select, immediate format
//   RSsel, RTsel, SZ     register-port selects, pass-through/zero-base mode
//   Branch, Jump, JR, JAL  PC control
//   MemRead, MemWrite, MemToReg, RegWrite  memory / write-back strobes
//   PilhaE, PilhaOP      stack enable / operation
//   IOE, IOsel           I/O port enable, 1 = input
//   HLT                  processor halted
//   state [2:0]          debug view of the FSM state
//
// IN handshake: io_valid is a level-sensitive "data present" flag and it is
// only looked at in IOWAIT. The cycle that sees io_valid=1 is the transfer
// cycle: RegWrite is asserted and the FSM returns to FETCH. There is no
// ready signal. IOE/IOsel held high in IOWAIT tell the device that the
// processor is waiting.
module controle_multiciclo #(
    parameter int OPW      = 6,
    parameter int ALUW     = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            io_valid,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic [ALUW-1:0] ALUOp,
    output logic            ALUsrc,
    output logic [1:0]      IMsel,
    output logic            RSsel,
    output logic            RTsel,
    output logic            SZ,
    output logic            Branch,
    output logic            Jump,
    output logic            JR,
    output logic            JAL,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            RegWrite,
    output logic            PilhaE,
    output logic            PilhaOP,
    output logic            IOE,
    output logic            IOsel,
    output logic            HLT,
    output logic [2:0]      state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_IOWAIT = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // Instruction classes. Only the class is needed to choose the next state.
    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_ALU   = 4'd1;  // ALU R, ALU imm, move, li
    localparam logic [3:0] C_BR    = 4'd2;
    localparam logic [3:0] C_LOAD  = 4'd3;
    localparam logic [3:0] C_STORE = 4'd4;
    localparam logic [3:0] C_J     = 4'd5;
    localparam logic [3:0] C_JR    = 4'd6;
    localparam logic [3:0] C_JAL   = 4'd7;
    localparam logic [3:0] C_IN    = 4'd8;
    localparam logic [3:0] C_OUT   = 4'd9;
    localparam logic [3:0] C_HLT   = 4'd10;

    logic [2:0]      state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;

    // Decode latch
    logic [3:0]      cls_q;
    logic [ALUW-1:0] aluop_q;
    logic            alusrc_q, rssel_q, rtsel_q, sz_q, pilha_q;
    logic [1:0]      imsel_q;

    // Combinational decode of the live opcode (used only in DECODE)
    logic [3:0]      dec_cls;
    logic [ALUW-1:0] dec_aluop;
    logic            dec_alusrc, dec_rssel, dec_rtsel, dec_sz, dec_pilha;
    logic [1:0]      dec_imsel;
    logic [31:0]     op_u;

    assign op_u = 32'(opcode);

    always_comb begin
        dec_cls    = C_NOP;
        dec_aluop  = '0;
        dec_alusrc = 1'b0;
        dec_imsel  = 2'd0;
        dec_rssel  = 1'b0;
        dec_rtsel  = 1'b0;
        dec_sz     = 1'b0;
        dec_pilha  = 1'b0;
        case (op_u) inside
            [32'h00:32'h06]: begin dec_cls = C_ALU; dec_aluop = ALUW'(op_u); end
            32'h07: begin dec_cls = C_ALU; dec_alusrc = 1'b1; dec_aluop = ALUW'(0); end
            32'h08: begin dec_cls = C_ALU; dec_alusrc = 1'b1; dec_aluop = ALUW'(1); end
            32'h09: begin dec_cls = C_ALU; dec_alusrc = 1'b1; dec_aluop = ALUW'(2); end
            32'h0A: begin dec_cls = C_ALU; dec_alusrc = 1'b1; dec_aluop = ALUW'(4); end
            32'h0B: begin dec_cls = C_ALU; dec_alusrc = 1'b1; dec_aluop = ALUW'(5); end
            32'h0C: begin dec_cls = C_ALU; dec_aluop = ALUW'(13); end  // sr
            32'h0D: begin dec_cls = C_ALU; dec_aluop = ALUW'(12); end  // sl
            [32'h0E:32'h12]: begin
                dec_cls   = C_BR;
                dec_rssel = 1'b1;
                dec_rtsel = 1'b1;
                dec_imsel = 2'd1;
                case (op_u)
                    32'h0E:  dec_aluop = ALUW'(8);   // bge
                    32'h0F:  dec_aluop = ALUW'(7);   // beq
                    32'h10:  dec_aluop = ALUW'(11);  // bgt
                    32'h11:  dec_aluop = ALUW'(10);  // blt
                    default: dec_aluop = ALUW'(9);   // ble
                endcase
            end
            32'h13: begin dec_cls = C_ALU; dec_sz = 1'b1; dec_rtsel = 1'b1; end
            32'h14: begin
                dec_cls = C_ALU; dec_sz = 1'b1; dec_alusrc = 1'b1; dec_imsel = 2'd1;
            end
            32'h15: begin
                dec_cls = C_LOAD; dec_sz = 1'b1; dec_alusrc = 1'b1; dec_imsel = 2'd1;
            end
            32'h16: begin
                dec_cls = C_STORE; dec_sz = 1'b1; dec_alusrc = 1'b1; dec_imsel = 2'd1;
                dec_rssel = 1'b1;
            end
            32'h17: dec_cls = C_LOAD;
            32'h18: begin dec_cls = C_STORE; dec_rssel = 1'b1; dec_rtsel = 1'b1; end
            32'h19: begin dec_cls = C_LOAD; dec_alusrc = 1'b1; end
            32'h1A: begin
                dec_cls = C_STORE; dec_alusrc = 1'b1; dec_rssel = 1'b1; dec_rtsel = 1'b1;
            end
            32'h1B: begin dec_cls = C_J; dec_imsel = 2'd2; end
            32'h1C: begin dec_cls = C_JR; dec_rssel = 1'b1; end
            32'h1D: begin dec_cls = C_JAL; dec_imsel = 2'd2; end
            32'h1E: begin dec_cls = C_STORE; dec_rssel = 1'b1; dec_pilha = 1'b1; end
            32'h1F: begin dec_cls = C_LOAD; dec_pilha = 1'b1; end
            32'h20: dec_cls = C_IN;
            32'h21: begin dec_cls = C_OUT; dec_rssel = 1'b1; end
            32'h23: dec_cls = C_HLT;
            default: dec_cls = C_NOP;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    C_HLT:   state_d = S_HALT;
                    C_IN:    state_d = S_IOWAIT;
                    C_NOP:   state_d = S_FETCH;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_ALU:   state_d = S_WB;
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        wcnt_d  = 4'(MEM_WAIT);
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (wcnt_q == 4'd0) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_IOWAIT: if (io_valid) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wcnt_q   <= 4'd0;
            cls_q    <= C_NOP;
            aluop_q  <= '0;
            alusrc_q <= 1'b0;
            imsel_q  <= 2'd0;
            rssel_q  <= 1'b0;
            rtsel_q  <= 1'b0;
            sz_q     <= 1'b0;
            pilha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_DECODE) begin
                cls_q    <= dec_cls;
                aluop_q  <= dec_aluop;
                alusrc_q <= dec_alusrc;
                imsel_q  <= dec_imsel;
                rssel_q  <= dec_rssel;
                rtsel_q  <= dec_rtsel;
                sz_q     <= dec_sz;
                pilha_q  <= dec_pilha;
            end
        end
    end

    assign state = state_q;

    // Outputs. rst gates every output so that nothing leaks while reset is
    // held, including the FETCH strobes of the reset state.
    logic sel_en;
    assign sel_en = !rst && (state_q == S_EXEC || state_q == S_MEM ||
                             state_q == S_WB   || state_q == S_IOWAIT);

    always_comb begin
        ALUOp   = sel_en ? aluop_q  : '0;
        ALUsrc  = sel_en ? alusrc_q : 1'b0;
        IMsel   = sel_en ? imsel_q  : 2'd0;
        RSsel   = sel_en ? rssel_q  : 1'b0;
        RTsel   = sel_en ? rtsel_q  : 1'b0;
        SZ      = sel_en ? sz_q     : 1'b0;
        PilhaE  = sel_en ? pilha_q  : 1'b0;
        PilhaOP = sel_en ? pilha_q  : 1'b0;
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        JR       = 1'b0;
        JAL      = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        IOE      = 1'b0;
        IOsel    = 1'b0;
        HLT      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_BR:  Branch = 1'b1;
                        C_J:   begin Jump = 1'b1; PCWrite = 1'b1; end
                        C_JR:  begin Jump = 1'b1; PCWrite = 1'b1; JR = 1'b1; end
                        C_JAL: begin
                            Jump = 1'b1; PCWrite = 1'b1; JAL = 1'b1; RegWrite = 1'b1;
                        end
                        C_OUT: IOE = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MemRead  = (cls_q == C_LOAD);
                    MemWrite = (cls_q == C_STORE);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = (cls_q == C_LOAD);
                end
                S_IOWAIT: begin
                    IOE      = 1'b1;
                    IOsel    = 1'b1;
                    RegWrite = io_valid;
                end
                S_HALT:  HLT = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       io_valid = 1'b0;

    logic       PCWrite, IRWrite, ALUsrc, RSsel, RTsel, SZ, Branch, Jump, JR, JAL;
    logic       MemRead, MemWrite, MemToReg, RegWrite, PilhaE, PilhaOP, IOE, IOsel, HLT;
    logic [3:0] ALUOp;
    logic [1:0] IMsel;
    logic [2:0] state;

    controle_multiciclo #(.OPW(6), .ALUW(4), .MEM_WAIT(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .io_valid(io_valid),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUOp(ALUOp), .ALUsrc(ALUsrc),
        .IMsel(IMsel), .RSsel(RSsel), .RTsel(RTsel), .SZ(SZ), .Branch(Branch),
        .Jump(Jump), .JR(JR), .JAL(JAL), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .PilhaE(PilhaE), .PilhaOP(PilhaOP),
        .IOE(IOE), .IOsel(IOsel), .HLT(HLT), .state(state)
    );

    // clock
    always #5 clk = ~clk;

    // Strobe bit positions inside the packed observation vector
    localparam logic [16:0] S_PCW  = 17'h10000;
    localparam logic [16:0] S_IRW  = 17'h08000;
    localparam logic [16:0] S_ASRC = 17'h04000;
    localparam logic [16:0] S_SZ   = 17'h02000;
    localparam logic [16:0] S_BR   = 17'h01000;
    localparam logic [16:0] S_J    = 17'h00800;
    localparam logic [16:0] S_JR   = 17'h00400;
    localparam logic [16:0] S_JAL  = 17'h00200;
    localparam logic [16:0] S_MR   = 17'h00100;
    localparam logic [16:0] S_MW   = 17'h00080;
    localparam logic [16:0] S_M2R  = 17'h00040;
    localparam logic [16:0] S_RW   = 17'h00020;
    localparam logic [16:0] S_PE   = 17'h00010;
    localparam logic [16:0] S_PO   = 17'h00008;
    localparam logic [16:0] S_IOE  = 17'h00004;
    localparam logic [16:0] S_IOS  = 17'h00002;
    localparam logic [16:0] S_HLT  = 17'h00001;

    logic [16:0] strb;
    logic [24:0] outs;
    assign strb = {PCWrite, IRWrite, ALUsrc, SZ, Branch, Jump, JR, JAL, MemRead, MemWrite,
                   MemToReg, RegWrite, PilhaE, PilhaOP, IOE, IOsel, HLT};
    assign outs = {ALUOp, IMsel, RSsel, RTsel, strb};

    function automatic logic [24:0] ev(input logic [3:0] a, input logic [1:0] im,
                                       input logic rs, input logic rt, input logic [16:0] s);
        return {a, im, rs, rt, s};
    endfunction

    localparam logic [24:0] F_EXP = {8'h00, S_PCW | S_IRW};

    // scoreboard counters
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Check one cycle (state + all outputs), then advance to the next negedge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [24:0] e);
        #1;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " outs"}, 32'(outs), 32'(e));
        @(negedge clk);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset outs", 32'(outs), 32'd0);
        rst = 1'b0;

        // add 0x00: 0,1,2,4
        opcode = 6'h00;
        cyc("add F", 3'd0, F_EXP);
        cyc("add D", 3'd1, '0);
        cyc("add E", 3'd2, '0);
        cyc("add W", 3'd4, ev(4'd0, 2'd0, 1'b0, 1'b0, S_RW));

        // subi 0x08, opcode changed after DECODE must be ignored
        opcode = 6'h08;
        cyc("subi F", 3'd0, F_EXP);
        cyc("subi D", 3'd1, '0);
        opcode = 6'h23;
        cyc("subi E", 3'd2, ev(4'd1, 2'd0, 1'b0, 1'b0, S_ASRC));
        cyc("subi W", 3'd4, ev(4'd1, 2'd0, 1'b0, 1'b0, S_ASRC | S_RW));

        // lw 0x15 with MEM_WAIT=3: 8 cycles, MemRead for 4
        opcode = 6'h15;
        cyc("lw F", 3'd0, F_EXP);
        cyc("lw D", 3'd1, '0);
        cyc("lw E", 3'd2, ev(4'd0, 2'd1, 1'b0, 1'b0, S_ASRC | S_SZ));
        for (int i = 0; i < 4; i++)
            cyc("lw M", 3'd3, ev(4'd0, 2'd1, 1'b0, 1'b0, S_ASRC | S_SZ | S_MR));
        cyc("lw W", 3'd4, ev(4'd0, 2'd1, 1'b0, 1'b0, S_ASRC | S_SZ | S_RW | S_M2R));

        // jal 0x1D
        opcode = 6'h1D;
        cyc("jal F", 3'd0, F_EXP);
        cyc("jal D", 3'd1, '0);
        cyc("jal E", 3'd2, ev(4'd0, 2'd2, 1'b0, 1'b0, S_J | S_JAL | S_PCW | S_RW));

        // jr 0x1C
        opcode = 6'h1C;
        cyc("jr F", 3'd0, F_EXP);
        cyc("jr D", 3'd1, '0);
        cyc("jr E", 3'd2, ev(4'd0, 2'd0, 1'b1, 1'b0, S_J | S_JR | S_PCW));

        // out 0x21
        opcode = 6'h21;
        cyc("out F", 3'd0, F_EXP);
        cyc("out D", 3'd1, '0);
        cyc("out E", 3'd2, ev(4'd0, 2'd0, 1'b1, 1'b0, S_IOE));

        // andi 0x0A -> ALUOp 4
        opcode = 6'h0A;
        cyc("andi F", 3'd0, F_EXP);
        cyc("andi D", 3'd1, '0);
        cyc("andi E", 3'd2, ev(4'd4, 2'd0, 1'b0, 1'b0, S_ASRC));
        cyc("andi W", 3'd4, ev(4'd4, 2'd0, 1'b0, 1'b0, S_ASRC | S_RW));

        // move 0x13
        opcode = 6'h13;
        cyc("move F", 3'd0, F_EXP);
        cyc("move D", 3'd1, '0);
        cyc("move E", 3'd2, ev(4'd0, 2'd0, 1'b0, 1'b1, S_SZ));
        cyc("move W", 3'd4, ev(4'd0, 2'd0, 1'b0, 1'b1, S_SZ | S_RW));

        // push 0x1E: store, 7 cycles
        opcode = 6'h1E;
        cyc("push F", 3'd0, F_EXP);
        cyc("push D", 3'd1, '0);
        cyc("push E", 3'd2, ev(4'd0, 2'd0, 1'b1, 1'b0, S_PE | S_PO));
        for (int i = 0; i < 4; i++)
            cyc("push M", 3'd3, ev(4'd0, 2'd0, 1'b1, 1'b0, S_PE | S_PO | S_MW));

        // in 0x20, io_valid low for 5 IOWAIT cycles then high
        opcode = 6'h20;
        io_valid = 1'b0;
        cyc("in F", 3'd0, F_EXP);
        cyc("in D", 3'd1, '0);
        for (int i = 0; i < 5; i++)
            cyc("in wait", 3'd5, ev(4'd0, 2'd0, 1'b0, 1'b0, S_IOE | S_IOS));
        io_valid = 1'b1;
        cyc("in xfer", 3'd5, ev(4'd0, 2'd0, 1'b0, 1'b0, S_IOE | S_IOS | S_RW));

        // in with io_valid already high on entry: write in first IOWAIT cycle
        cyc("in2 F", 3'd0, F_EXP);
        cyc("in2 D", 3'd1, '0);
        cyc("in2 xfer", 3'd5, ev(4'd0, 2'd0, 1'b0, 1'b0, S_IOE | S_IOS | S_RW));
        io_valid = 1'b0;

        // undefined 0x3F: FETCH, DECODE, FETCH
        opcode = 6'h3F;
        cyc("nop F", 3'd0, F_EXP);
        cyc("nop D", 3'd1, '0);

        // sw 0x16 aborted by reset in MEM
        opcode = 6'h16;
        cyc("sw F", 3'd0, F_EXP);
        cyc("sw D", 3'd1, '0);
        cyc("sw E", 3'd2, ev(4'd0, 2'd1, 1'b1, 1'b0, S_ASRC | S_SZ));
        cyc("sw M0", 3'd3, ev(4'd0, 2'd1, 1'b1, 1'b0, S_ASRC | S_SZ | S_MW));
        cyc("sw M1", 3'd3, ev(4'd0, 2'd1, 1'b1, 1'b0, S_ASRC | S_SZ | S_MW));
        rst = 1'b1;
        #1;
        check("sw rst state", 32'(state), 32'd0);
        check("sw rst outs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        opcode = 6'h23;
        cyc("post rst F", 3'd0, F_EXP);

        // hlt 0x23: HALT sticky while opcode toggles
        cyc("hlt D", 3'd1, '0);
        for (int i = 0; i < 22; i++) begin
            opcode = opcode ^ 6'h3F;
            cyc("halt", 3'd6, ev(4'd0, 2'd0, 1'b0, 1'b0, S_HLT));
        end
        rst = 1'b1;
        #1;
        check("halt rst state", 32'(state), 32'd0);
        check("halt rst outs", 32'(outs), 32'd0);
        @(negedge clk);
        #1;
        check("halt rst held outs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        opcode = 6'h00;
        cyc("after halt F", 3'd0, F_EXP);
        cyc("after halt D", 3'd1, '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
